long2double: RTL and testbench

LONG2DOUBLE -- requirements
Module: long2double

---
 rtl/long2double.sv | 111 +++++++++++
 tb/tb_long2double.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/long2double.sv
// Three-stage integer to IEEE-754 binary64 converter (FCVT.D.W/WU/L/LU).
// One operation in flight; a new one may be accepted in the cycle the previous result is valid.
module long2double (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ena,
  input  logic        i_signed,
  input  logic        i_w32,
  input  logic [63:0] i_a,
  output logic [63:0] o_res,
  output logic        o_valid,
  output logic        o_busy
);

  logic [2:0]  ena_q, ena_d;
  logic        busy_q, busy_d;
  logic        sign1_q, sign1_d;
  logic [63:0] mag_q, mag_d;
  logic        sign2_q, sign2_d;
  logic [63:0] norm_q, norm_d;
  logic [5:0]  lzc_q, lzc_d;
  logic [63:0] res_q, res_d;

  logic        accept;
  logic [63:0] operand;
  logic        neg;
  logic [5:0]  lzc;
  logic        round_up;
  logic [52:0] frac;
  logic        carry;
  logic [10:0] exp_biased;

  // Stage 1: handshake, operand widening and sign/magnitude split
  always_comb begin
    accept  = i_ena & (~busy_q | ena_q[2]);
    ena_d   = {ena_q[1:0], accept};
    busy_d  = busy_q;
    if (accept)
      busy_d = 1'b1;
    else if (ena_q[2])
      busy_d = 1'b0;

    if (i_w32)
      operand = i_signed ? {{32{i_a[31]}}, i_a[31:0]} : {32'd0, i_a[31:0]};
    else
      operand = i_a;
    neg     = i_signed & operand[63];
    sign1_d = sign1_q;
    mag_d   = mag_q;
    if (accept) begin
      sign1_d = neg;
      mag_d   = neg ? (~operand + 64'd1) : operand;
    end
  end

  // Stage 2: leading-zero count and normalisation; highest set bit wins
  always_comb begin
    lzc = 6'd0;
    for (int i = 0; i < 64; i++) begin
      if (mag_q[i])
        lzc = 6'(63 - i);
    end
    sign2_d = sign2_q;
    lzc_d   = lzc_q;
    norm_d  = norm_q;
    if (ena_q[0]) begin
      sign2_d = sign1_q;
      lzc_d   = lzc;
      norm_d  = mag_q << lzc;
    end
  end

  // Stage 3: round to nearest-even; the hidden bit is implied, so a carry
  // out of the 52-bit fraction means the mantissa rolled over to 2.0
  always_comb begin
    round_up   = norm_q[10] & ((|norm_q[9:0]) | norm_q[11]);
    frac       = {1'b0, norm_q[62:11]} + {52'd0, round_up};
    carry      = frac[52];
    exp_biased = 11'd1086 - {5'd0, lzc_q} + {10'd0, carry};
    res_d      = res_q;
    if (ena_q[1])
      res_d = norm_q[63] ? {sign2_q, exp_biased, frac[51:0]} : 64'd0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ena_q   <= 3'd0;
      busy_q  <= 1'b0;
      sign1_q <= 1'b0;
      mag_q   <= 64'd0;
      sign2_q <= 1'b0;
      norm_q  <= 64'd0;
      lzc_q   <= 6'd0;
      res_q   <= 64'd0;
    end else begin
      ena_q   <= ena_d;
      busy_q  <= busy_d;
      sign1_q <= sign1_d;
      mag_q   <= mag_d;
      sign2_q <= sign2_d;
      norm_q  <= norm_d;
      lzc_q   <= lzc_d;
      res_q   <= res_d;
    end
  end

  assign o_res   = res_q;
  assign o_valid = ena_q[2];
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_long2double.sv
// Scoreboard bench for long2double: directed IEEE vectors, handshake and reset
// scenarios, then randomized operands against a real-arithmetic reference.
module tb_long2double;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_ena;
  logic        i_signed;
  logic        i_w32;
  logic [63:0] i_a;
  logic [63:0] o_res;
  logic        o_valid;
  logic        o_busy;

  long2double dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_ena    (i_ena),
    .i_signed (i_signed),
    .i_w32    (i_w32),
    .i_a      (i_a),
    .o_res    (o_res),
    .o_valid  (o_valid),
    .o_busy   (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [63:0] res;
    int          vc;
    string       name;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          free_cyc = 0;
  logic [63:0] last_res = 64'd0;

  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  // Reference: exact magnitude split into two 32-bit halves, so the only
  // rounding is the single double-precision addition (round-to-nearest-even).
  function automatic logic [63:0] ref_cvt(logic [63:0] a, bit s, bit w);
    logic [63:0] op;
    logic [63:0] mag;
    bit          negv;
    real         r;
    if (w)
      op = s ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]};
    else
      op = a;
    negv = s && op[63];
    mag  = negv ? (64'd0 - op) : op;
    r = real'(longint'({32'd0, mag[63:32]})) * 4294967296.0
        + real'(longint'({32'd0, mag[31:0]}));
    if (negv)
      r = -r;
    return $realtobits(r);
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic scramble();
    i_a      = {$urandom, $urandom};
    i_signed = 1'($urandom);
    i_w32    = 1'($urandom);
  endtask

  task automatic send(logic [63:0] a, bit s, bit w, logic [63:0] expv, string name);
    exp_t e;
    while (cyc < free_cyc)
      step();
    i_ena    = 1'b1;
    i_a      = a;
    i_signed = s;
    i_w32    = w;
    e.res  = expv;
    e.vc   = cyc + 3;
    e.name = name;
    q.push_back(e);
    free_cyc = cyc + 3;
    step();
    i_ena = 1'b0;
    scramble();
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on o_valid and checks busy/hold every cycle
  initial forever begin
    bit   exp_busy;
    exp_t e;
    @(negedge i_clk);
    exp_busy = (q.size() > 0) && (cyc >= q[0].vc - 2);
    chk("busy", {63'd0, o_busy}, {63'd0, exp_busy});
    if (o_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        chk({e.name, "_res"}, o_res, e.res);
        chk({e.name, "_latency"}, 64'(cyc), 64'(e.vc));
        $display("[TB] cycle %0d %s res=%h exp=%h", cyc, e.name, o_res, e.res);
        last_res = e.res;
      end
    end else begin
      chk("hold", o_res, last_res);
      if (q.size() > 0 && q[0].vc < cyc) begin
        e = q.pop_front();
        chk({e.name, "_timeout"}, 64'd0, 64'd1);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a;
    bit          s, w;
    int          gap;

    i_rst = 1'b1; i_ena = 1'b0; i_signed = 1'b0; i_w32 = 1'b0; i_a = 64'd0;
    #1;
    chk("reset_res", o_res, 64'd0);
    chk("reset_valid", {63'd0, o_valid}, 64'd0);
    chk("reset_busy", {63'd0, o_busy}, 64'd0);
    repeat (3) step();
    i_rst = 1'b0;
    step();
    free_cyc = cyc;

    send(64'd1,                  1, 0, 64'h3FF0000000000000, "one_s64");
    send(64'hFFFFFFFFFFFFFFFF,   1, 0, 64'hBFF0000000000000, "minus1_s64");
    send(64'hFFFFFFFFFFFFFFFF,   0, 0, 64'h43F0000000000000, "umax_u64");
    send(64'h8000000000000000,   1, 0, 64'hC3E0000000000000, "smin_s64");
    send(64'hFFFFFFFF80000000,   1, 1, 64'hC1E0000000000000, "smin_s32");
    send(64'hFFFFFFFF80000000,   0, 1, 64'h41E0000000000000, "u32_2p31");
    send(64'h0020000000000001,   0, 0, 64'h4340000000000000, "tie_even");
    send(64'h0020000000000003,   0, 0, 64'h4340000000000002, "tie_odd");
    send(64'd0,                  0, 0, 64'h0000000000000000, "zero_u");
    send(64'd0,                  1, 0, 64'h0000000000000000, "zero_s");

    // Pulses at T, T+1 (ignored while busy) and T+3
    send(64'd2, 1, 0, 64'h4000000000000000, "hs_first");
    i_ena = 1'b1; i_a = 64'd5; i_signed = 1'b0; i_w32 = 1'b0;
    step();
    i_ena = 1'b0;
    send(64'd3, 0, 0, 64'h4008000000000000, "hs_third");

    // Reset in cycle T+2 of an operation
    send(64'd7, 0, 0, 64'h401C000000000000, "aborted");
    step();
    i_rst = 1'b1;
    #1;
    chk("midreset_busy", {63'd0, o_busy}, 64'd0);
    chk("midreset_res", o_res, 64'd0);
    q.delete();
    last_res = 64'd0;
    step();
    i_rst = 1'b0;
    repeat (5) step();
    free_cyc = cyc;
    send(64'd1, 1, 0, 64'h3FF0000000000000, "after_reset");

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0: a = {$urandom, $urandom};
        1: a = {$urandom, $urandom} >> $urandom_range(0, 63);
        2: a = (64'd1 << $urandom_range(53, 63)) | 64'($urandom_range(0, 4095));
        default: a = 64'd0 - (64'($urandom) >> $urandom_range(0, 31));
      endcase
      s = 1'($urandom);
      w = 1'($urandom);
      send(a, s, w, ref_cvt(a, s, w), "rand");
      gap = $urandom_range(0, 3);
      for (int j = 0; j < gap; j++) begin
        if (cyc < free_cyc && $urandom_range(0, 1) == 1)
          i_ena = 1'b1;
        step();
        i_ena = 1'b0;
        scramble();
      end
    end

    for (int j = 0; j < 20 && q.size() > 0; j++)
      step();
    if (q.size() > 0)
      chk("drain", 64'(q.size()), 64'd0);
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
